csa_mult_sched: RTL and testbench
=================================

// Module: csa_mult_sched
// PURPOSE
//   Round-robin scheduler sharing one 8x8 carry-save-tree multiplier (CSA stages + final CPA) between NREQ requesters.
//   Captures one operand pair per grant, drives the shared tree and waits LAT cycles (multicycle path).
//   Captures the 16-bit product and returns it with the requester ID over a valid/ready response channel.
//   Sits between client units and the combinational multiplier datapath.
// PARAMETERS
//   NREQ   4   number of requesters (2..8)
//   LAT    3   cycles mul_p needs to settle after mul_a/mul_b change (1..15)
//   IDW    2   requester ID width, equals clog2(NREQ)
// PORTS
//   clk        in   1        single clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   req_valid  in   NREQ     per-requester operand valid
//   req_a      in   NREQ*8   flattened multiplicands; requester i at [8*i+7:8*i]
//   req_b      in   NREQ*8   flattened multipliers, same packing
//   req_ready  out  NREQ     one-hot accept strobe; transfer when valid&ready
//   mul_a      out  8        operand A to shared multiplier (registered)
//   mul_b      out  8        operand B to shared multiplier (registered)
//   mul_p      in   16       product from shared multiplier (final CPA output)
//   busy       out  1        high whenever FSM is not IDLE
//   rsp_valid  out  1        product valid
//   rsp_ready  in   1        consumer accepts product
//   rsp_data   out  16       unsigned product a*b
//   rsp_id     out  IDW      index of requester that issued the operands
// BEHAVIOUR
//   Reset (async, rst_n=0): FSM=IDLE, rr_ptr=0, wait_cnt=0.
//     All outputs 0: req_ready, mul_a/b, busy, rsp_valid, rsp_data, rsp_id.
//   FSM states: IDLE, WAIT, DONE.
//   IDLE: if any req_valid, grant the first valid at or after rr_ptr (cyclic search).
//     req_ready[g]=1 combinationally for that cycle only.
//     At the edge: mul_a/mul_b<=operands[g], rsp_id<=g, rr_ptr<=(g+1)%NREQ, wait_cnt<=LAT-1, go WAIT.
//     If no requester is valid: stay IDLE, all req_ready=0.
//   WAIT: wait_cnt decrements each cycle.
//     When wait_cnt==0: rsp_data<=mul_p, rsp_valid<=1, go DONE.
//     Product is therefore visible exactly LAT+1 cycles after the grant edge.
//   DONE: hold rsp_valid/rsp_data/rsp_id stable until rsp_ready=1.
//     On rsp_valid&rsp_ready: rsp_valid<=0, go IDLE.
//     Next grant happens at the earliest in the following cycle; there is no same-cycle re-grant.
//   req_ready is 0 in WAIT and DONE. Requesters hold valid and operands stable until they are granted.
//   mul_a/mul_b keep their last operands after completion; they are not cleared.
//   rr_ptr wraps from NREQ-1 to 0.
//   Simultaneous requests are resolved by the rotating pointer. With all NREQ valid, grants cycle 0,1,2,3,0...
//   A req_valid deasserted before grant is ignored. Deassertion after grant has no effect on the operation in flight.
//   Reset mid-operation abandons the product; no response is issued.
//   Arithmetic: unsigned 8x8 -> 16; no truncation or overflow is possible.
// CONFIGURATION
//   CSA_ZERO_BYPASS_EN defined:
//     In IDLE, if the granted req_a==0 or req_b==0, skip WAIT.
//     rsp_data<=0, rsp_valid<=1 and go DONE at the grant edge; response is visible 1 cycle after grant.
//     mul_a/mul_b are not updated, which saves tree toggling.
//   Not defined: every grant takes the full LAT+1 latency, including zero operands.
// STRUCTURE
//   Shared package/include csa_mult_pkg: state encodings ST_IDLE=2'd0, ST_WAIT=2'd1, ST_DONE=2'd2.
//     Also holds OPW=8, PW=16 and the clog2 helper function.
//   Sub-module rr_arbiter: inputs NREQ-bit req and ptr.
//     Outputs one-hot gnt, the encoded index and any_gnt. Purely combinational.
//   Top level holds the FSM, wait counter, operand/response registers and pointer update.
// TESTING
//   1 Single: req0 a=8'd13 b=8'd11, rsp_ready=1 -> rsp_valid at grant+LAT+1 with rsp_data=143, rsp_id=0.
//   2 Fairness: all 4 valid, a=i+1, b=10 -> ids 0,1,2,3,0 in order; data 10,20,30,40.
//   3 Backpressure: rsp_ready=0 for 5 cycles -> rsp_data/rsp_id stable; no new req_ready until the handshake.
//   4 Extremes: a=255 b=255 -> 65025; a=1 b=255 -> 255; pointer wraps after id 3.
//   5 Reset mid-WAIT: rst_n low 1 cycle -> all outputs 0 immediately, no rsp_valid; next grant goes to req0.
//   6 Zero bypass, a=0 b=77: with CSA_ZERO_BYPASS_EN -> rsp_valid 1 cycle after grant, data 0.
//     Without the macro -> data 0 after LAT+1 cycles.

Source files
------------

// File: rtl/csa_mult_pkg.sv
// Shared definitions for the shared-multiplier scheduler: FSM encodings, datapath widths, clog2 helper.
// Optional feature macro used by the top level: CSA_ZERO_BYPASS_EN.
package csa_mult_pkg;

  localparam int OPW = 8;
  localparam int PW  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return (res < 1) ? 1 : res;
  endfunction

endpackage

// File: rtl/csa_mult_sched_rr_arbiter.sv
// Combinational rotating-priority arbiter: grants the first set request at or after ptr_i, searching cyclically.
module rr_arbiter
  import csa_mult_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  // Slot k holds the request that sits k positions after the pointer.
  logic [NREQ-1:0] rot_req;
  logic [IDW-1:0]  rot_idx [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
      always_comb begin
        int j;
        j = (int'(ptr_i) + gi) % NREQ;
        rot_idx[gi] = IDW'(j);
        rot_req[gi] = req_i[j];
      end
    end
  endgenerate

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any_o && rot_req[k]) begin
        any_o             = 1'b1;
        idx_o             = rot_idx[k];
        gnt_o[rot_idx[k]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/csa_mult_sched.sv
// Round-robin scheduler sharing one combinational 8x8 multiplier; waits LAT cycles per product.
// Optional zero-operand shortcut enabled by defining CSA_ZERO_BYPASS_EN.
module csa_mult_sched
  import csa_mult_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = 3,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*OPW-1:0] req_a,
  input  logic [NREQ*OPW-1:0] req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic [OPW-1:0]      mul_a,
  output logic [OPW-1:0]      mul_b,
  input  logic [PW-1:0]       mul_p,
  output logic                busy,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [PW-1:0]       rsp_data,
  output logic [IDW-1:0]      rsp_id
);

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [3:0]      wait_cnt_q, wait_cnt_d;
  logic [OPW-1:0]  mul_a_q, mul_a_d;
  logic [OPW-1:0]  mul_b_q, mul_b_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [PW-1:0]   rsp_data_q, rsp_data_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;

  logic [OPW-1:0]  op_a [NREQ];
  logic [OPW-1:0]  op_b [NREQ];
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic [OPW-1:0]  sel_a, sel_b;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign op_a[gi] = req_a[OPW*gi +: OPW];
      assign op_b[gi] = req_b[OPW*gi +: OPW];
    end
  endgenerate

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  assign sel_a = op_a[gnt_idx];
  assign sel_b = op_b[gnt_idx];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    wait_cnt_d  = wait_cnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    req_ready   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          req_ready = gnt;
          rsp_id_d  = gnt_idx;
          rr_ptr_d  = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
`ifdef CSA_ZERO_BYPASS_EN
          // A zero operand gives a zero product; leave the tree inputs untouched.
          if (sel_a == '0 || sel_b == '0) begin
            rsp_data_d  = '0;
            rsp_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            mul_a_d    = sel_a;
            mul_b_d    = sel_b;
            wait_cnt_d = 4'(LAT - 1);
            state_d    = ST_WAIT;
          end
`else
          mul_a_d    = sel_a;
          mul_b_d    = sel_b;
          wait_cnt_d = 4'(LAT - 1);
          state_d    = ST_WAIT;
`endif
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == '0) begin
          rsp_data_d  = mul_p;
          rsp_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      wait_cnt_q  <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      wait_cnt_q  <= wait_cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_csa_mult_sched.sv
// Self-checking bench for csa_mult_sched: vector table, corner sequences and randomized traffic vs. a behavioural model.
module tb_csa_mult_sched;

  localparam int NREQ = 4;
  localparam int LAT  = 3;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        mul_a, mul_b;
  logic [15:0]       mul_p;
  logic              busy, rsp_valid, rsp_ready;
  logic [15:0]       rsp_data;
  logic [IDW-1:0]    rsp_id;

  always #5 clk = ~clk;

  csa_mult_sched #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  // Multiplier model: product only correct once operands have been stable for LAT-1 full cycles.
  logic [15:0] last_ab = 16'h0000;
  int          age = 20;
  int          eff_age;
  always @(posedge clk) begin
    if ({mul_a, mul_b} != last_ab) begin
      last_ab <= {mul_a, mul_b};
      age     <= 1;
    end else if (age < 20) begin
      age <= age + 1;
    end
  end
  always_comb begin
    eff_age = ({mul_a, mul_b} == last_ab) ? age : 0;
    mul_p   = (eff_age >= LAT - 1) ? (16'(mul_a) * 16'(mul_b)) : 16'hBAD5;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model state
  logic [NREQ-1:0] pend = '0;
  logic [7:0]      pa [NREQ];
  logic [7:0]      pb [NREQ];
  int mptr = 0, cyc = 0, grant_cyc = 0, exp_id = 0, exp_data = 0, exp_lat = 0;
  bit outst = 0, seen = 0;
  int done_cnt = 0, last_data = 0, last_id = 0;
  int log_id[$];
  int log_data[$];

  function automatic int model_pick();
    for (int k = 0; k < NREQ; k++)
      if (pend[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
    return 0;
  endfunction

  // One clock cycle: drive, sample half-way, compare against model, advance.
  task automatic step(input bit rr);
    int  g;
    bit  was_out;
    for (int i = 0; i < NREQ; i++) begin
      req_a[8*i +: 8] = pa[i];
      req_b[8*i +: 8] = pb[i];
    end
    req_valid = pend;
    rsp_ready = rr;
    #1;
    was_out = outst;
    chk("busy", int'(busy), int'(was_out));
    if (was_out || pend == '0) begin
      chk("req_ready_zero", int'(req_ready), 0);
    end else begin
      g = model_pick();
      chk("grant", int'(req_ready), 1 << g);
      outst     = 1;
      seen      = 0;
      exp_id    = g;
      exp_data  = int'(pa[g]) * int'(pb[g]);
      grant_cyc = cyc;
`ifdef CSA_ZERO_BYPASS_EN
      exp_lat = (pa[g] == 0 || pb[g] == 0) ? 1 : LAT + 1;
`else
      exp_lat = LAT + 1;
`endif
      mptr    = (g + 1) % NREQ;
      pend[g] = 1'b0;
    end
    if (!was_out) begin
      chk("rsp_valid_idle", int'(rsp_valid), 0);
    end else if (rsp_valid) begin
      if (!seen) begin
        chk("latency", cyc - grant_cyc, exp_lat);
        seen = 1;
      end
      chk("rsp_data", int'(rsp_data), exp_data);
      chk("rsp_id", int'(rsp_id), exp_id);
      if (rr) begin
        outst     = 0;
        last_data = int'(rsp_data);
        last_id   = int'(rsp_id);
        done_cnt++;
        log_id.push_back(last_id);
        log_data.push_back(last_data);
        $display("txn %0d: id=%0d data=%0d lat=%0d", done_cnt, last_id, last_data, cyc - grant_cyc);
      end
    end else if (cyc - grant_cyc > exp_lat) begin
      chk("rsp_timeout", int'(rsp_valid), 1);
      outst = 0;
    end
    @(posedge clk);
    #2;
    cyc++;
  endtask

  typedef struct {
    int id;
    int a;
    int b;
    int exp_p;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int base;
    int zero_sent;
    vecs[0] = '{0, 13, 11, 143};
    vecs[1] = '{3, 255, 255, 65025};
    vecs[2] = '{1, 1, 255, 255};
    vecs[3] = '{2, 0, 77, 0};
    vecs[4] = '{0, 77, 0, 0};
    vecs[5] = '{3, 200, 3, 600};
    for (int i = 0; i < NREQ; i++) begin
      pa[i] = 8'd0;
      pb[i] = 8'd0;
    end
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;

    // Reset state
    #12;
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_mul_a", int'(mul_a), 0);
    chk("rst_mul_b", int'(mul_b), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_data", int'(rsp_data), 0);
    chk("rst_rsp_id", int'(rsp_id), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Vector table, one transaction each
    foreach (vecs[v]) begin
      base = done_cnt;
      pend[vecs[v].id] = 1'b1;
      pa[vecs[v].id]   = 8'(vecs[v].a);
      pb[vecs[v].id]   = 8'(vecs[v].b);
      for (int c = 0; c < 40 && done_cnt == base; c++) step(1'b1);
      chk("tbl_done", done_cnt - base, 1);
      chk("tbl_data", last_data, vecs[v].exp_p);
      chk("tbl_id", last_id, vecs[v].id);
    end

    // Reset in the middle of WAIT abandons the product
    pend[1] = 1'b1; pa[1] = 8'd21; pb[1] = 8'd3;
    step(1'b1);
    step(1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_mul_a", int'(mul_a), 0);
    chk("mid_rst_rsp_valid", int'(rsp_valid), 0);
    chk("mid_rst_rsp_id", int'(rsp_id), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    outst = 0;
    mptr  = 0;
    for (int c = 0; c < LAT + 3; c++) step(1'b1);
    pend[0] = 1'b1; pa[0] = 8'd4; pb[0] = 8'd5;
    pend[3] = 1'b1; pa[3] = 8'd6; pb[3] = 8'd7;
    base = done_cnt;
    for (int c = 0; c < 40 && done_cnt < base + 2; c++) step(1'b1);
    chk("post_rst_first_id", log_id[base], 0);
    chk("post_rst_second_id", log_id[base + 1], 3);

    // Fairness: all valid, requester 0 re-requests after its grant
    base = done_cnt;
    zero_sent = 0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b1;
      pa[i]   = 8'(i + 1);
      pb[i]   = 8'd10;
    end
    for (int c = 0; c < 80 && done_cnt < base + 5; c++) begin
      if (!pend[0] && zero_sent == 0) begin
        pend[0] = 1'b1;
        zero_sent = 1;
      end
      step(1'b1);
    end
    chk("fair_count", done_cnt - base, 5);
    for (int k = 0; k < 5 && base + k < log_id.size(); k++) begin
      chk("fair_id", log_id[base + k], k % NREQ);
      chk("fair_data", log_data[base + k], 10 * ((k % NREQ) + 1));
    end

    // Backpressure: consumer stalls, another requester waits
    base = done_cnt;
    pend[2] = 1'b1; pa[2] = 8'd9; pb[2] = 8'd9;
    step(1'b1);
    pend[1] = 1'b1; pa[1] = 8'd2; pb[1] = 8'd50;
    for (int c = 0; c < LAT + 6; c++) step(1'b0);
    chk("bp_held_valid", int'(rsp_valid), 1);
    for (int c = 0; c < 40 && done_cnt < base + 2; c++) step(1'b1);
    chk("bp_first_id", log_id[base], 2);
    chk("bp_first_data", log_data[base], 81);
    chk("bp_second_id", log_id[base + 1], 1);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          case ($urandom_range(0, 7))
            0:       begin pa[i] = 8'd0;   pb[i] = 8'($urandom); end
            1:       begin pa[i] = 8'd255; pb[i] = 8'd255; end
            2:       begin pa[i] = 8'($urandom); pb[i] = 8'd0; end
            default: begin pa[i] = 8'($urandom); pb[i] = 8'($urandom); end
          endcase
        end
      end
      step($urandom_range(0, 3) != 0);
    end
    for (int c = 0; c < 200 && (pend != '0 || outst); c++) step(1'b1);
    chk("drain_pending", int'(pend), 0);
    chk("drain_outstanding", int'(outst), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
